// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Single-port data memory with a load/store front end. It accepts
//            one request at a time. Stores write byte lanes on the acceptance
//            edge. Loads read the word on the acceptance edge, then align and
//            extend it. The response is presented RD_LAT edges after
//            acceptance, counting the acceptance edge, and is held until
//            rsp_ready. Misaligned or out-of-range accesses do not touch
//            memory and return rsp_err = 1 with zero data.
// Ports    : clk, reset_n (async, active low)
//            req_valid/req_ready/req_we/req_addr/req_size/req_unsigned/
//            req_wdata - request channel
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err - response channel
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int         C_IDX_W  = $clog2(DEPTH);
    localparam int         C_LANES  = XLEN / 8;
    localparam logic [1:0] C_LAT_M1 = 2'(RD_LAT - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_RESP = 2'd2;

    logic [XLEN-1:0]    r_mem [DEPTH];
    logic [1:0]         r_state;
    logic [1:0]         r_cnt;
    logic [XLEN-1:0]    r_rdata;
    logic               r_err;

    logic [C_IDX_W-1:0] w_idx;
    logic [2:0]         w_off;
    logic               w_mis;
    logic               w_oor;
    logic               w_err;
    logic               w_accept;
    logic [C_LANES-1:0] w_bmask;
    logic [XLEN-1:0]    w_wdata_sh;
    logic [XLEN-1:0]    w_rword_sh;
    logic [XLEN-1:0]    w_load;

    assign w_idx = req_addr[C_IDX_W+2:3];
    assign w_off = req_addr[2:0];
    assign w_oor = |req_addr[XLEN-1:C_IDX_W+3];

    always_comb begin
        w_mis = 1'b0;
        case (req_size)
            2'd1:    w_mis = w_off[0];
            2'd2:    w_mis = |w_off[1:0];
            2'd3:    w_mis = |w_off;
            default: w_mis = 1'b0;
        endcase
    end

    assign w_err     = w_mis | w_oor;
    assign req_ready = (r_state == C_IDLE) && reset_n;
    assign w_accept  = req_valid && req_ready;

    // Lane enables and write data are shifted up to the addressed lane.
    always_comb begin
        w_bmask = '0;
        case (req_size)
            2'd0:    w_bmask = C_LANES'(8'h01) << w_off;
            2'd1:    w_bmask = C_LANES'(8'h03) << w_off;
            2'd2:    w_bmask = C_LANES'(8'h0F) << w_off;
            default: w_bmask = C_LANES'(8'hFF) << w_off;
        endcase
    end

    assign w_wdata_sh = req_wdata << {w_off, 3'b000};

    // Memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < C_LANES; b++) begin
                if (w_bmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Load alignment: shift the addressed lane down to bit 0, then extend.
    // The sign bit is masked by req_unsigned; size 3 needs no extension.
    assign w_rword_sh = r_mem[w_idx] >> {w_off, 3'b000};

    always_comb begin
        w_load = '0;
        case (req_size)
            2'd0:    w_load = {{(XLEN-8){~req_unsigned & w_rword_sh[7]}},
                               w_rword_sh[7:0]};
            2'd1:    w_load = {{(XLEN-16){~req_unsigned & w_rword_sh[15]}},
                               w_rword_sh[15:0]};
            2'd2:    w_load = {{(XLEN-32){~req_unsigned & w_rword_sh[31]}},
                               w_rword_sh[31:0]};
            default: w_load = w_rword_sh;
        endcase
    end

    // The response is captured at acceptance, so rsp_rdata and rsp_err are
    // stable for the whole WAIT/RESP period regardless of backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= C_IDLE;
            r_cnt   <= 2'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    r_cnt <= 2'd0;
                    if (w_accept) begin
                        r_err   <= w_err;
                        r_rdata <= (req_we || w_err) ? '0 : w_load;
                        if (RD_LAT == 1) begin
                            r_state <= C_RESP;
                        end else begin
                            r_state <= C_WAIT;
                            r_cnt   <= 2'd1;
                        end
                    end
                end
                C_WAIT: begin
                    if (r_cnt == C_LAT_M1) begin
                        r_state <= C_RESP;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                C_RESP: begin
                    if (rsp_ready) begin
                        r_state <= C_IDLE;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

    assign rsp_valid = (r_state == C_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter XLEN, default 64: data and address width in bits; legal value is 64.
REQ-002 Parameter DEPTH, default 256: number of XLEN-bit words; power of two, 2..4096.
REQ-003 Parameter RD_LAT, default 1: cycles from request acceptance to response; legal 1..4.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  XLEN  byte address.
REQ-010 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and for size 3.
REQ-012 req_wdata  input  XLEN  store data, right-aligned (bits [8*2^size-1:0] used).
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_rdata  output  XLEN  load result, extended; 0 for stores and for errors.
REQ-016 rsp_err  output  1  access was misaligned or out of range.

Function
REQ-017 Request acceptance SHALL occur on the rising edge where req_valid && req_ready; at most one request outstanding.
REQ-018 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Transitions: IDLE->RESP on acceptance when RD_LAT = 1; IDLE->WAIT on acceptance when RD_LAT > 1; WAIT->RESP when the latency counter reaches RD_LAT-1; RESP->IDLE on rsp_valid && rsp_ready.
REQ-020 rsp_valid SHALL be 1 exactly in RESP, first asserted RD_LAT edges after the acceptance edge.
REQ-021 rsp_rdata and rsp_err SHALL be held stable while rsp_valid = 1 and rsp_ready = 0.
REQ-022 After the handshake edge, req_ready SHALL be 1 in the following cycle; back-to-back throughput is therefore one request per RD_LAT+1 cycles minimum.
REQ-023 Word index SHALL be req_addr[log2(DEPTH)+2:3]; byte lane offset SHALL be req_addr[2:0].
REQ-024 Misaligned means req_addr is not a multiple of 2^req_size bytes.
REQ-025 Out of range means any of req_addr[XLEN-1:log2(DEPTH)+3] is nonzero.
REQ-026 On a misaligned or out-of-range request, memory SHALL NOT be modified; the response SHALL carry rsp_err = 1 and rsp_rdata = 0 with normal latency.
REQ-027 A legal store SHALL write only the 2^size byte lanes starting at the lane offset, on the acceptance edge; other lanes are unchanged.
REQ-028 A legal load SHALL read the word at the acceptance edge, select the addressed lanes, and extend them to XLEN per req_unsigned.
REQ-029 A store response SHALL carry rsp_err = 0 and rsp_rdata = 0.
REQ-030 A load issued after a store response has completed SHALL observe the stored data.
REQ-031 Request inputs outside acceptance edges SHALL be ignored.

Reset
REQ-032 Asserting reset_n = 0 SHALL immediately force the FSM to IDLE, the latency counter to 0, rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0; req_ready = 0 while reset is asserted and 1 from the first cycle after release.
REQ-033 Reset mid-operation SHALL discard any pending response; a store already accepted remains committed.
REQ-034 Memory contents SHALL NOT be reset; a load from a never-written word returns an undefined value.

Verification
REQ-035 Store then load, RD_LAT = 1: store size 3 addr 0x10 data 0x1122334455667788; load size 3 addr 0x10 -> rsp_rdata = 0x1122334455667788, rsp_err = 0, rsp_valid one edge after each acceptance.
REQ-036 Partial store with sign extension: after REQ-035, store size 0 addr 0x13 data 0xF0, then load size 0 addr 0x13 with unsigned = 0 -> 0xFFFFFFFFFFFFFFF0; unsigned = 1 -> 0xF0; load size 3 addr 0x10 -> 0x11223344F0667788.
REQ-037 Misaligned store: size 2 addr 0x12 -> rsp_err = 1, rsp_rdata = 0; a later size-3 load of 0x10 is unchanged.
REQ-038 Out-of-range load with DEPTH = 256: load addr 0x800 -> rsp_err = 1, rsp_rdata = 0.
REQ-039 Backpressure with RD_LAT = 3: hold rsp_ready = 0 for 5 cycles -> rsp_valid rises 3 edges after acceptance, data stays stable, req_ready stays 0; release -> IDLE and req_ready = 1 next cycle.
REQ-040 Reset in WAIT: assert reset_n = 0 one cycle after acceptance -> rsp_valid = 0 immediately and no response issued after release.
